// File: rtl/dffnrsnq_preset_pkg.sv
// Shared types and constants for the dffnrsnq preset sequencer.
package dffnrsnq_preset_pkg;

  localparam int unsigned CNT_W = 8;

  localparam int unsigned PULSE_CYC_MIN  = 1;
  localparam int unsigned PULSE_CYC_MAX  = 255;
  localparam int unsigned SETTLE_CYC_MIN = 1;
  localparam int unsigned SETTLE_CYC_MAX = 255;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StGate    = 3'd1,
    StPulse   = 3'd2,
    StRelease = 3'd3,
    StDone    = 3'd4
  } state_e;

  // Out-of-range cycle counts are pulled into the legal window so the counter never loads 0.
  function automatic logic [CNT_W-1:0] clamp_cnt(input int unsigned v, input int unsigned lo,
                                                  input int unsigned hi);
    int unsigned c;
    c = (v < lo) ? lo : ((v > hi) ? hi : v);
    return CNT_W'(c);
  endfunction

endpackage

// File: rtl/dffnrsnq_preset_timer.sv
// Loadable down-counter shared by the PULSE and RELEASE phases; last_o flags count == 1.
module dffnrsnq_preset_timer
  import dffnrsnq_preset_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q > CNT_W'(1))) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Falling-edge state to match the bank it controls.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dffnrsnq_preset_ctrl.sv
// Presets a dffnrsnq bank via its SETN/RN pins with the bank clock gated.
// Optional readback compare enabled by defining PRESET_READBACK_EN.
module dffnrsnq_preset_ctrl
  import dffnrsnq_preset_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PULSE_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic             CLKN,
  input  logic             RN,
  input  logic             req,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] mask,
  output logic             busy,
  output logic             done,
  output logic             bank_clk_en,
  output logic [WIDTH-1:0] bank_setn,
  output logic [WIDTH-1:0] bank_rn
`ifdef PRESET_READBACK_EN
  ,
  input  logic [WIDTH-1:0] bank_q,
  output logic             mismatch
`endif
);

  localparam logic [CNT_W-1:0] PulseLoad  = clamp_cnt(PULSE_CYC, PULSE_CYC_MIN, PULSE_CYC_MAX);
  localparam logic [CNT_W-1:0] SettleLoad = clamp_cnt(SETTLE_CYC, SETTLE_CYC_MIN, SETTLE_CYC_MAX);

  state_e           state_q;
  logic [WIDTH-1:0] pat_q, mask_q;
  logic             busy_q, done_q, clk_en_q;
  logic [WIDTH-1:0] setn_q, rn_q;
`ifdef PRESET_READBACK_EN
  logic             mismatch_q;
`endif

  logic             tmr_load, tmr_dec, tmr_last;
  logic [CNT_W-1:0] tmr_val;

  // Counter is loaded on the edge that enters PULSE or RELEASE.
  always_comb begin
    tmr_load = (state_q == StGate) || ((state_q == StPulse) && tmr_last);
    tmr_val  = (state_q == StGate) ? PulseLoad : SettleLoad;
    tmr_dec  = (state_q == StPulse) || (state_q == StRelease);
  end

  dffnrsnq_preset_timer u_timer (
    .clk_i      (CLKN),
    .rst_ni     (RN),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .last_o     (tmr_last)
  );

  always_ff @(negedge CLKN or negedge RN) begin
    if (!RN) begin
      state_q    <= StIdle;
      pat_q      <= '0;
      mask_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      clk_en_q   <= 1'b1;
      setn_q     <= '1;
      rn_q       <= '1;
`ifdef PRESET_READBACK_EN
      mismatch_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            pat_q      <= pattern;
            mask_q     <= mask;
            busy_q     <= 1'b1;
            clk_en_q   <= 1'b0;
            state_q    <= StGate;
`ifdef PRESET_READBACK_EN
            mismatch_q <= 1'b0;
`endif
          end
        end
        StGate: begin
          // Set and reset masks are disjoint, so no bit sees both pins low.
          setn_q  <= ~(mask_q & pat_q);
          rn_q    <= ~(mask_q & ~pat_q);
          state_q <= StPulse;
        end
        StPulse: begin
          if (tmr_last) begin
            setn_q  <= '1;
            rn_q    <= '1;
            state_q <= StRelease;
          end
        end
        StRelease: begin
          if (tmr_last) begin
            done_q   <= 1'b1;
            clk_en_q <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
`ifdef PRESET_READBACK_EN
          mismatch_q <= |((bank_q ^ pat_q) & mask_q);
`endif
        end
        default: begin
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          clk_en_q <= 1'b1;
          setn_q   <= '1;
          rn_q     <= '1;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign bank_clk_en = clk_en_q;
  assign bank_setn   = setn_q;
  assign bank_rn     = rn_q;
`ifdef PRESET_READBACK_EN
  assign mismatch    = mismatch_q;
`endif

endmodule

// File: tb/tb_dffnrsnq_preset_ctrl.sv
// Scoreboard bench for dffnrsnq_preset_ctrl: driver predicts operations, monitor checks timelines.
module tb_dffnrsnq_preset_ctrl;

  localparam int unsigned P   = 2;
  localparam int unsigned S   = 1;
  localparam int          LAT = 2 + P + S;

  typedef struct {
    logic [7:0] setn;
    logic [7:0] rn;
    int         acc;
    logic [7:0] bq;
    logic       mm;
  } exp_t;

  logic       CLKN = 1'b1;
  logic       RN   = 1'b0;
  logic       req  = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [7:0] mask    = 8'h00;
  logic       busy, done, bank_clk_en;
  logic [7:0] bank_setn, bank_rn;
`ifdef PRESET_READBACK_EN
  logic [7:0] bank_q = 8'h00;
  logic       mismatch;
`endif

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   free_at = 0;
  exp_t q[$];

  // Monitor state.
  exp_t cur;
  bit   active = 1'b0;
  int   idx    = 0;
  bit   mm_pend = 1'b0;
  logic mm_exp  = 1'b0;

  dffnrsnq_preset_ctrl #(
    .WIDTH      (8),
    .PULSE_CYC  (P),
    .SETTLE_CYC (S)
  ) dut (
    .CLKN        (CLKN),
    .RN          (RN),
    .req         (req),
    .pattern     (pattern),
    .mask        (mask),
    .busy        (busy),
    .done        (done),
    .bank_clk_en (bank_clk_en),
    .bank_setn   (bank_setn),
    .bank_rn     (bank_rn)
`ifdef PRESET_READBACK_EN
    ,
    .bank_q      (bank_q),
    .mismatch    (mismatch)
`endif
  );

  always #5 CLKN = ~CLKN;
  always @(negedge CLKN) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Drive one cycle of inputs; predict acceptance from the idle-window rule.
  task automatic step(input bit r, input logic [7:0] p, input logic [7:0] m,
                      input logic [7:0] flip);
    exp_t e;
    @(posedge CLKN);
    req     = r;
    pattern = p;
    mask    = m;
    if (r && RN && (cyc + 1 >= free_at)) begin
      e.setn  = ~(m & p);
      e.rn    = ~(m & ~p);
      e.acc   = cyc + 1;
      e.bq    = p ^ flip;
      e.mm    = |(flip & m);
      q.push_back(e);
      free_at = cyc + 1 + LAT + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, 8'h00);
  endtask

  function automatic logic [7:0] rnd_flip();
    logic [7:0] one;
    one = 8'h01;
    return ($urandom_range(0, 1) == 0) ? 8'h00 : (one << $urandom_range(0, 7));
  endfunction

  // Monitor: samples mid-cycle, on the edge opposite the active one.
  always @(posedge CLKN) begin
    if (!RN) begin
      active  = 1'b0;
      mm_pend = 1'b0;
      chk("rst_setn", {24'h0, bank_setn}, 32'hFF);
      chk("rst_rn", {24'h0, bank_rn}, 32'hFF);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_clk_en", {31'h0, bank_clk_en}, 32'h1);
`ifdef PRESET_READBACK_EN
      chk("rst_mismatch", {31'h0, mismatch}, 32'h0);
`endif
    end else begin
      if (!active && busy) begin
        if (q.size() == 0) begin
          chk("unexpected_accept", 32'h1, 32'h0);
        end else begin
          cur = q.pop_front();
          chk("accept_cycle", cyc, cur.acc);
          active  = 1'b1;
          idx     = 0;
          mm_pend = 1'b0;
`ifdef PRESET_READBACK_EN
          bank_q = cur.bq;
          chk("mismatch_cleared", {31'h0, mismatch}, 32'h0);
`endif
        end
      end
      if (active) begin
        chk("setn", {24'h0, bank_setn}, (idx >= 1 && idx <= P) ? {24'h0, cur.setn} : 32'hFF);
        chk("rn", {24'h0, bank_rn}, (idx >= 1 && idx <= P) ? {24'h0, cur.rn} : 32'hFF);
        chk("clk_en", {31'h0, bank_clk_en}, (idx == LAT - 1) ? 32'h1 : 32'h0);
        chk("done", {31'h0, done}, (idx == LAT - 1) ? 32'h1 : 32'h0);
        chk("busy", {31'h0, busy}, 32'h1);
        if (idx == LAT - 1) begin
          active  = 1'b0;
          mm_pend = 1'b1;
          mm_exp  = cur.mm;
        end
        idx++;
      end else if (!busy) begin
        chk("idle_done", {31'h0, done}, 32'h0);
        chk("idle_clk_en", {31'h0, bank_clk_en}, 32'h1);
        chk("idle_pins", {16'h0, bank_setn, bank_rn}, 32'hFFFF);
`ifdef PRESET_READBACK_EN
        if (mm_pend) chk("mismatch", {31'h0, mismatch}, {31'h0, mm_exp});
`endif
      end
      chk("pin_overlap", {24'h0, ~bank_setn & ~bank_rn}, 32'h0);
    end
  end

  initial begin
    int a;
    RN = 1'b0;
    repeat (3) @(posedge CLKN);
    RN = 1'b1;
    free_at = cyc + 1;

    step(1'b1, 8'hA5, 8'hFF, 8'h00);
    idle(8);
    step(1'b1, 8'hA5, 8'hFF, 8'h01);
    idle(8);
    step(1'b1, 8'hFF, 8'h0F, 8'h00);
    idle(8);
    step(1'b1, 8'h3C, 8'h00, 8'hFF);
    idle(8);

    // req held high with pattern churning every cycle.
    for (int i = 0; i < 30; i++) step(1'b1, $urandom, $urandom, rnd_flip());
    idle(8);

    // Asynchronous reset in the middle of PULSE.
    step(1'b1, $urandom, 8'hFF, 8'h00);
    a = cyc + 1;
    step(1'b0, 8'h00, 8'h00, 8'h00);
    while (cyc < a + 1) step(1'b0, 8'h00, 8'h00, 8'h00);
    #2 RN = 1'b0;
    #1;
    chk("async_rst_setn", {24'h0, bank_setn}, 32'hFF);
    chk("async_rst_rn", {24'h0, bank_rn}, 32'hFF);
    chk("async_rst_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge CLKN);
    RN = 1'b1;
    free_at = cyc + 1;
    idle(4);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 2) == 0, $urandom,
           ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), rnd_flip());
    end
    idle(10);

    chk("pending_ops", q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
